packet_switch_fifo_pkt_drain: RTL and testbench
===============================================

Name: packet_switch_fifo_pkt_drain

Overview:
- Downstream consumer of the packet switch show-ahead SC FIFO wrapper (scfifo mode, clk1 domain).
- Pops framed words {sop, eop, data} from the FIFO and presents them as a valid/ready packet stream through a 2-entry skid buffer.
- Enforces packet framing and a maximum packet length, discarding or terminating malformed packets.
- fifo_rdreq is driven from registered state and fifo_rdempty only, never combinationally from out_ready.

Parameters:
- DATA_W, 64, payload width per word.
- MAX_PKT_WORDS, 256, maximum words per packet, sop and eop words included; must be ≥2.
- CNT_W, $clog2(MAX_PKT_WORDS+1), width of the word counter.

Ports:
- clk  input  1  single clock, same as FIFO clk1.
- rst  input  1  synchronous, active-high reset.
- fifo_dout  input  DATA_W+2  show-ahead FIFO head word {sop, eop, data}; valid when !fifo_rdempty.
- fifo_rdempty  input  1  FIFO empty.
- fifo_rdreq  output  1  pop; head word consumed this cycle.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_W  payload.
- out_sop  output  1  start of packet.
- out_eop  output  1  end of packet.
- out_err  output  1  qualifies out_eop; packet was terminated abnormally.
- err_framing  output  1  one-cycle pulse on a framing violation.
- err_len  output  1  one-cycle pulse on a length violation.

Behaviour:
- Reset:
  - out_valid, fifo_rdreq, err_framing and err_len are 0.
  - Skid occupancy is 0; FSM is in IDLE; word counter is 0.
  - out_data/sop/eop/err are don't-care while out_valid=0.
- fifo_rdreq = !rst & !fifo_rdempty & (occ_q < 2).
  - occ_q is the registered skid occupancy (0..2).
  - Never asserted while fifo_rdempty=1, which guarantees no FIFO underflow.
- Each popped word is classified by the FSM in the same cycle, then either written into the skid or discarded.
- Latency: FIFO head to out_valid is 1 cycle.
- Full throughput: with out_ready held at 1, occupancy stays at 1 and one word passes per cycle.
- Skid buffer:
  - Handshake: output transfer when out_valid & out_ready.
  - out_valid = (occ_q != 0), presenting the oldest entry.
  - Written and drained in the same cycle: occupancy is unchanged and order is preserved.
  - occ_q never exceeds 2.
- FSM states and transitions:
  - IDLE:
    - Word with sop=1 and eop=1: forward; stay IDLE.
    - Word with sop=1 and eop=0: forward; counter=1; go to IN_PKT.
    - Word with sop=0: discard; pulse err_framing; stay IDLE.
  - IN_PKT:
    - Word with sop=0 and eop=1: forward; go to IDLE.
    - Word with sop=0 and eop=0: forward; counter+1. If counter+1 == MAX_PKT_WORDS, the word is forwarded with eop=1 and err=1, err_len pulses, and the FSM goes to DROP.
    - Word with sop=1: forward as sop=0, eop=1, err=1; pulse err_framing; go to DROP. This terminates the broken packet and drops the new one.
  - DROP:
    - Every word is discarded.
    - A word with eop=1 returns the FSM to IDLE, including a word that has sop=1 and eop=1.
- Simultaneous errors: a sop word arriving on the count limit is reported as a framing error only.
- out_err=1 only on a word with out_eop=1.
- Counter saturates and never wraps.
- Reset mid-packet:
  - Skid contents are flushed and the FSM returns to IDLE.
  - Remaining FIFO words of that packet (FIFO sclr'd by the same rst) are handled by the normal IDLE rules.

Optional Feature:
- Macro: PACKET_SWITCH_PKT_DRAIN_STATS_EN.
- When defined, adds three outputs, each a 32-bit saturating counter cleared by rst:
  - stat_pkts: incremented on each eop transfer with err=0.
  - stat_err_pkts: incremented on each eop transfer with err=1.
  - stat_drop_words: incremented on each discarded word.
- When not defined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package packet_switch_pkt_drain_pkg holds:
  - enum drain_state_e {IDLE, IN_PKT, DROP}.
  - Struct pkt_word_t {sop, eop, err, data}.
  - SOP/EOP bit-position constants for fifo_dout.
- One sub-module, packet_switch_skid2: generic 2-entry valid/ready skid buffer parameterised by width, with an occupancy output.

Test Plan:
- Two well-formed packets of 3 and 1 words, FIFO never empty, out_ready=1.
  - Expect 4 consecutive out_valid cycles with sop/eop at words 0, 2 and 3, and no error pulses.
- Same traffic with out_ready toggling 1,0,0,1.
  - Expect fifo_rdreq=0 while occ_q=2, no word lost or duplicated, order preserved, and no rdreq while rdempty=1.
- Word with sop=0, eop=0, data=0xAA while IDLE.
  - Expect the word discarded, err_framing pulses once, and out_valid stays 0.
- MAX_PKT_WORDS=4 and a 6-word packet.
  - Expect 4 words out, the 4th with eop=1 and err=1; err_len pulses; words 5 and 6 dropped; the next packet passes cleanly.
- sop arriving at word 3 of a 5-word packet.
  - Expect word 3 output as eop=1, err=1 with err_framing pulsed; the new packet dropped through its eop; FSM back in IDLE.
- rst asserted for 1 cycle mid-packet with occ_q=2.
  - Expect out_valid=0 and fifo_rdreq=0 the next cycle; the following sop-led packet is forwarded intact.

Source files
------------

// File: rtl/packet_switch_pkt_drain_pkg.sv
// ============================================================================
// Module      : packet_switch_pkt_drain_pkg
// Description : Shared types and constants for the packet-switch FIFO drain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package packet_switch_pkt_drain_pkg;

  // Payload width carried by pkt_word_t; the drain supports DATA_W up to this.
  localparam int C_PKT_DATA_W = 64;

  // sop/eop sit directly above the payload in fifo_dout: {sop, eop, data}.
  localparam int C_EOP_OFS = 0;
  localparam int C_SOP_OFS = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } drain_state_e;

  typedef struct packed {
    logic                    sop;
    logic                    eop;
    logic                    err;
    logic [C_PKT_DATA_W-1:0] data;
  } pkt_word_t;

endpackage

`default_nettype wire

// File: rtl/packet_switch_skid2.sv
// ============================================================================
// Module      : packet_switch_skid2
// Description : Generic 2-entry valid/ready skid buffer with occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_switch_skid2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [1:0]       o_occ
);

  logic [1:0]       r_occ;
  logic [WIDTH-1:0] r_ent0;
  logic [WIDTH-1:0] r_ent1;
  logic             w_wr;
  logic             w_rd;

  assign o_in_ready  = (r_occ < 2'd2);
  assign o_out_valid = (r_occ != 2'd0);
  assign o_out_data  = r_ent0;
  assign o_occ       = r_occ;
  assign w_wr        = i_in_valid & o_in_ready;
  assign w_rd        = o_out_valid & i_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ <= 2'd0;
    end else begin
      r_occ <= r_occ + {1'b0, w_wr} - {1'b0, w_rd};
    end
  end

  // r_ent0 always holds the oldest entry; payload needs no reset.
  always_ff @(posedge clk) begin
    case ({w_wr, w_rd})
      2'b10: begin
        if (r_occ == 2'd0) r_ent0 <= i_in_data;
        else               r_ent1 <= i_in_data;
      end
      2'b01: begin
        r_ent0 <= r_ent1;
      end
      2'b11: begin
        if (r_occ == 2'd1) begin
          r_ent0 <= i_in_data;
        end else begin
          r_ent0 <= r_ent1;
          r_ent1 <= i_in_data;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/packet_switch_fifo_pkt_drain.sv
// ============================================================================
// Module      : packet_switch_fifo_pkt_drain
// Description : Pops framed words from a show-ahead FIFO, enforces framing and
//               max length, and presents a valid/ready stream (DATA_W <= 64).
//               Optional stats counters: PACKET_SWITCH_PKT_DRAIN_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_switch_fifo_pkt_drain
  import packet_switch_pkt_drain_pkg::*;
#(
  parameter int DATA_W        = 64,
  parameter int MAX_PKT_WORDS = 256,
  parameter int CNT_W         = $clog2(MAX_PKT_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W+1:0] fifo_dout,
  input  logic              fifo_rdempty,
  output logic              fifo_rdreq,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_err,
  output logic              err_framing,
  output logic              err_len
`ifdef PACKET_SWITCH_PKT_DRAIN_STATS_EN
  ,
  output logic [31:0]       stat_pkts,
  output logic [31:0]       stat_err_pkts,
  output logic [31:0]       stat_drop_words
`endif
);

  localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_PKT_WORDS);

  drain_state_e     r_state;
  drain_state_e     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_err_framing;
  logic             r_err_len;
  logic             w_err_framing;
  logic             w_err_len;
  logic             w_fwd;
  logic             w_sop;
  logic             w_eop;
  pkt_word_t        w_word;
  pkt_word_t        w_out_word;
  logic [1:0]       w_occ;
  logic             w_skid_rdy;

  assign w_sop      = fifo_dout[DATA_W + C_SOP_OFS];
  assign w_eop      = fifo_dout[DATA_W + C_EOP_OFS];
  assign w_cnt_inc  = (r_cnt == c_max_cnt) ? r_cnt : r_cnt + 1'b1;

  // Pop depends only on registered occupancy and FIFO empty, never on out_ready.
  assign fifo_rdreq = ~rst & ~fifo_rdempty & (w_occ < 2'd2);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_fwd         = 1'b0;
    w_err_framing = 1'b0;
    w_err_len     = 1'b0;
    w_word.sop    = w_sop;
    w_word.eop    = w_eop;
    w_word.err    = 1'b0;
    w_word.data   = C_PKT_DATA_W'(fifo_dout[DATA_W-1:0]);
    if (fifo_rdreq) begin
      case (r_state)
        IDLE: begin
          if (w_sop) begin
            w_fwd = 1'b1;
            if (!w_eop) begin
              w_cnt_nxt   = CNT_W'(1);
              w_state_nxt = IN_PKT;
            end
          end else begin
            w_err_framing = 1'b1;
          end
        end
        IN_PKT: begin
          w_fwd = 1'b1;
          if (w_sop) begin
            // Close the broken packet here and drop the one that just started.
            w_word.sop    = 1'b0;
            w_word.eop    = 1'b1;
            w_word.err    = 1'b1;
            w_err_framing = 1'b1;
            w_state_nxt   = DROP;
          end else if (w_eop) begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == c_max_cnt) begin
              w_word.eop  = 1'b1;
              w_word.err  = 1'b1;
              w_err_len   = 1'b1;
              w_state_nxt = DROP;
            end
          end
        end
        DROP: begin
          if (w_eop) begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_err_framing <= 1'b0;
      r_err_len     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_err_framing <= w_err_framing;
      r_err_len     <= w_err_len;
    end
  end

  packet_switch_skid2 #(
    .WIDTH ($bits(pkt_word_t))
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (w_fwd & w_skid_rdy),
    .o_in_ready  (w_skid_rdy),
    .i_in_data   (w_word),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (w_out_word),
    .o_occ       (w_occ)
  );

  assign out_data    = w_out_word.data[DATA_W-1:0];
  assign out_sop     = w_out_word.sop;
  assign out_eop     = w_out_word.eop;
  assign out_err     = w_out_word.err;
  assign err_framing = r_err_framing;
  assign err_len     = r_err_len;

`ifdef PACKET_SWITCH_PKT_DRAIN_STATS_EN
  logic [31:0] r_stat_pkts;
  logic [31:0] r_stat_err_pkts;
  logic [31:0] r_stat_drop_words;
  logic        w_eop_xfer;

  assign w_eop_xfer = out_valid & out_ready & out_eop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_pkts       <= '0;
      r_stat_err_pkts   <= '0;
      r_stat_drop_words <= '0;
    end else begin
      if (w_eop_xfer && !out_err && (r_stat_pkts != '1))
        r_stat_pkts <= r_stat_pkts + 32'd1;
      if (w_eop_xfer && out_err && (r_stat_err_pkts != '1))
        r_stat_err_pkts <= r_stat_err_pkts + 32'd1;
      if (fifo_rdreq && !w_fwd && (r_stat_drop_words != '1))
        r_stat_drop_words <= r_stat_drop_words + 32'd1;
    end
  end

  assign stat_pkts       = r_stat_pkts;
  assign stat_err_pkts   = r_stat_err_pkts;
  assign stat_drop_words = r_stat_drop_words;
`endif

endmodule

`default_nettype wire

// File: tb/tb_packet_switch_fifo_pkt_drain.sv
// ============================================================================
// Module      : tb_packet_switch_fifo_pkt_drain
// Description : Directed self-checking bench for the FIFO packet drain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_packet_switch_fifo_pkt_drain;

  localparam int DATA_W = 64;
  localparam int MAXW   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W+1:0] fifo_dout = '0;
  logic              fifo_rdempty = 1'b1;
  logic              fifo_rdreq;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic              out_err;
  logic              err_framing;
  logic              err_len;
`ifdef PACKET_SWITCH_PKT_DRAIN_STATS_EN
  logic [31:0]       stat_pkts;
  logic [31:0]       stat_err_pkts;
  logic [31:0]       stat_drop_words;
`endif

  always #5 clk = ~clk;

  packet_switch_fifo_pkt_drain #(
    .DATA_W        (DATA_W),
    .MAX_PKT_WORDS (MAXW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_dout    (fifo_dout),
    .fifo_rdempty (fifo_rdempty),
    .fifo_rdreq   (fifo_rdreq),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_err      (out_err),
    .err_framing  (err_framing),
    .err_len      (err_len)
`ifdef PACKET_SWITCH_PKT_DRAIN_STATS_EN
    ,
    .stat_pkts       (stat_pkts),
    .stat_err_pkts   (stat_err_pkts),
    .stat_drop_words (stat_drop_words)
`endif
  );

  int tests  = 0;
  int failed = 0;

  logic [DATA_W+1:0] fifo_q[$];
  logic [DATA_W+2:0] obs[$];
  int                obs_cyc[$];
  int                cyc = 0;
  int                framing_cnt = 0;
  int                len_cnt = 0;
  int                valid_cnt = 0;
  int                occ_m = 0;
  int                occ2_seen = 0;
  bit                track = 1'b0;

  // Show-ahead FIFO model, cleared by the same rst as the drain.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (track)
      occ_m <= occ_m + (fifo_rdreq ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
    if (rst)
      fifo_q.delete();
    else if (fifo_rdreq && fifo_q.size() > 0)
      void'(fifo_q.pop_front());
    fifo_dout    <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
    fifo_rdempty <= (fifo_q.size() == 0);
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      obs.push_back({out_sop, out_eop, out_err, out_data});
      obs_cyc.push_back(cyc);
    end
    if (err_framing) framing_cnt++;
    if (err_len)     len_cnt++;
    if (out_valid)   valid_cnt++;
    if (!rst) begin
      tests++;
      assert ((fifo_rdreq && fifo_rdempty) === 1'b0) else begin
        failed++;
        $error("FAIL underflow: rdreq=%b rdempty=%b required no pop while empty", fifo_rdreq, fifo_rdempty);
      end
    end
    if (track) begin
      tests += 2;
      if (occ_m == 2 && !fifo_rdreq) occ2_seen++;
      assert (fifo_rdreq === (!fifo_rdempty && occ_m < 2)) else begin
        failed++;
        $error("FAIL rdreq_vs_occ: rdreq=%b required %b (occ=%0d)", fifo_rdreq, (!fifo_rdempty && occ_m < 2), occ_m);
      end
      assert (out_valid === (occ_m != 0)) else begin
        failed++;
        $error("FAIL valid_vs_occ: out_valid=%b required %b (occ=%0d)", out_valid, (occ_m != 0), occ_m);
      end
    end
  end

  function automatic logic [DATA_W+2:0] mk(input logic s, input logic e, input logic r, input logic [DATA_W-1:0] d);
    return {s, e, r, d};
  endfunction

  function automatic logic [DATA_W+2:0] obs_at(input int i);
    return (i < obs.size()) ? obs[i] : 'x;
  endfunction

  task automatic chk(input string tag, input logic [DATA_W+2:0] got, input logic [DATA_W+2:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic s, input logic e, input logic [DATA_W-1:0] d);
    fifo_q.push_back({s, e, d});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int           base;
  int           fr0;
  int           ln0;
  int           vc0;
  logic [3:0]   pat;

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    pat       = 4'b1001;
    step(3);

    // Reset state
    @(negedge clk);
    chk("rst_valid",   67'(out_valid),   67'd0);
    chk("rst_rdreq",   67'(fifo_rdreq),  67'd0);
    chk("rst_framing", 67'(err_framing), 67'd0);
    chk("rst_len",     67'(err_len),     67'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", 67'(out_valid),  67'd0);
    chk("idle_rdreq", 67'(fifo_rdreq), 67'd0);

    // Two good packets back to back, out_ready held high
    step(1);
    out_ready = 1'b1;
    base = obs.size(); fr0 = framing_cnt; ln0 = len_cnt;
    push(1'b1, 1'b0, 64'hA0);
    push(1'b0, 1'b0, 64'hA1);
    push(1'b0, 1'b1, 64'hA2);
    push(1'b1, 1'b1, 64'hB0);
    step(10);
    chk("t1_count", 67'(obs.size() - base), 67'd4);
    chk("t1_w0", obs_at(base + 0), mk(1'b1, 1'b0, 1'b0, 64'hA0));
    chk("t1_w1", obs_at(base + 1), mk(1'b0, 1'b0, 1'b0, 64'hA1));
    chk("t1_w2", obs_at(base + 2), mk(1'b0, 1'b1, 1'b0, 64'hA2));
    chk("t1_w3", obs_at(base + 3), mk(1'b1, 1'b1, 1'b0, 64'hB0));
    chk("t1_b2b", 67'((obs.size() >= base + 4) ? (obs_cyc[base + 3] - obs_cyc[base]) : -1), 67'd3);
    chk("t1_framing", 67'(framing_cnt - fr0), 67'd0);
    chk("t1_len",     67'(len_cnt - ln0),     67'd0);

    // Same traffic with out_ready toggling 1,0,0,1
    track = 1'b1;
    base = obs.size(); fr0 = framing_cnt;
    push(1'b1, 1'b0, 64'hC0);
    push(1'b0, 1'b0, 64'hC1);
    push(1'b0, 1'b1, 64'hC2);
    push(1'b1, 1'b1, 64'hD0);
    for (int i = 0; i < 16; i++) begin
      out_ready = pat[i % 4];
      step(1);
    end
    out_ready = 1'b1;
    step(4);
    track = 1'b0;
    chk("t2_count", 67'(obs.size() - base), 67'd4);
    chk("t2_w0", obs_at(base + 0), mk(1'b1, 1'b0, 1'b0, 64'hC0));
    chk("t2_w1", obs_at(base + 1), mk(1'b0, 1'b0, 1'b0, 64'hC1));
    chk("t2_w2", obs_at(base + 2), mk(1'b0, 1'b1, 1'b0, 64'hC2));
    chk("t2_w3", obs_at(base + 3), mk(1'b1, 1'b1, 1'b0, 64'hD0));
    chk("t2_occ2_stall", 67'(occ2_seen > 0), 67'd1);
    chk("t2_framing", 67'(framing_cnt - fr0), 67'd0);

    // Stray non-sop word while IDLE
    base = obs.size(); fr0 = framing_cnt; vc0 = valid_cnt;
    push(1'b0, 1'b0, 64'hAA);
    step(6);
    chk("t3_count",   67'(obs.size() - base),   67'd0);
    chk("t3_framing", 67'(framing_cnt - fr0),   67'd1);
    chk("t3_valid",   67'(valid_cnt - vc0),     67'd0);

    // 6-word packet against a 4-word limit, then a clean packet
    base = obs.size(); fr0 = framing_cnt; ln0 = len_cnt;
    push(1'b1, 1'b0, 64'hD0);
    push(1'b0, 1'b0, 64'hD1);
    push(1'b0, 1'b0, 64'hD2);
    push(1'b0, 1'b0, 64'hD3);
    push(1'b0, 1'b0, 64'hD4);
    push(1'b0, 1'b1, 64'hD5);
    push(1'b1, 1'b1, 64'hE0);
    step(14);
    chk("t4_count", 67'(obs.size() - base), 67'd5);
    chk("t4_w0", obs_at(base + 0), mk(1'b1, 1'b0, 1'b0, 64'hD0));
    chk("t4_w1", obs_at(base + 1), mk(1'b0, 1'b0, 1'b0, 64'hD1));
    chk("t4_w2", obs_at(base + 2), mk(1'b0, 1'b0, 1'b0, 64'hD2));
    chk("t4_w3", obs_at(base + 3), mk(1'b0, 1'b1, 1'b1, 64'hD3));
    chk("t4_next", obs_at(base + 4), mk(1'b1, 1'b1, 1'b0, 64'hE0));
    chk("t4_len",     67'(len_cnt - ln0),     67'd1);
    chk("t4_framing", 67'(framing_cnt - fr0), 67'd0);

    // sop arriving as word 3 of an open packet
    base = obs.size(); fr0 = framing_cnt; ln0 = len_cnt;
    push(1'b1, 1'b0, 64'hF0);
    push(1'b0, 1'b0, 64'hF1);
    push(1'b1, 1'b0, 64'h60);
    push(1'b0, 1'b0, 64'h61);
    push(1'b0, 1'b1, 64'h62);
    push(1'b1, 1'b1, 64'h70);
    step(14);
    chk("t5_count", 67'(obs.size() - base), 67'd4);
    chk("t5_w0", obs_at(base + 0), mk(1'b1, 1'b0, 1'b0, 64'hF0));
    chk("t5_w1", obs_at(base + 1), mk(1'b0, 1'b0, 1'b0, 64'hF1));
    chk("t5_w2", obs_at(base + 2), mk(1'b0, 1'b1, 1'b1, 64'h60));
    chk("t5_next", obs_at(base + 3), mk(1'b1, 1'b1, 1'b0, 64'h70));
    chk("t5_framing", 67'(framing_cnt - fr0), 67'd1);
    chk("t5_len",     67'(len_cnt - ln0),     67'd0);

    // Reset mid-packet with the skid full
    out_ready = 1'b0;
    base = obs.size();
    push(1'b1, 1'b0, 64'h90);
    push(1'b0, 1'b0, 64'h91);
    push(1'b0, 1'b0, 64'h92);
    step(6);
    @(negedge clk);
    chk("t6_full_valid", 67'(out_valid),  67'd1);
    chk("t6_full_rdreq", 67'(fifo_rdreq), 67'd0);
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_valid", 67'(out_valid),  67'd0);
    chk("t6_post_rdreq", 67'(fifo_rdreq), 67'd0);
    step(1);
    out_ready = 1'b1;
    push(1'b1, 1'b0, 64'hB1);
    push(1'b0, 1'b1, 64'hB2);
    step(8);
    chk("t6_count", 67'(obs.size() - base), 67'd2);
    chk("t6_w0", obs_at(base + 0), mk(1'b1, 1'b0, 1'b0, 64'hB1));
    chk("t6_w1", obs_at(base + 1), mk(1'b0, 1'b1, 1'b0, 64'hB2));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
